// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller.
// Holds the MIPS opcodes it decodes, the pc_sel encodings and the FSM states.
// Imported by pipeline_ctrl and hazard_detect.
package pipeline_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd1;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational decode of which ID sources are read, and load-use compare
// against the load currently in EX.
// Ports: ID opcode/rs/rt fields, EX load tracker in; hazard and is_jump out.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [5:0] J_OP   = OP_J,
  parameter logic [5:0] JAL_OP = OP_JAL
) (
  input  logic        id_valid,
  input  logic [15:0] id_hi,      // id_instr[31:16]: opcode, rs, rt
  input  logic        ex_load,
  input  logic [4:0]  ex_rt,
  output logic        hazard,
  output logic        is_jump
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_used;
  logic       rt_used;

  assign opcode = id_hi[15:10];
  assign rs     = id_hi[9:5];
  assign rt     = id_hi[4:0];

  assign is_jump = (opcode == J_OP) || (opcode == JAL_OP);
  assign rs_used = !is_jump;
  assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ)   || (opcode == OP_BNE);

  // A load into $zero never produces a value worth waiting for.
  assign hazard = id_valid && ex_load && (ex_rt != 5'd0) &&
                  ((rs_used && (rs == ex_rt)) || (rt_used && (rt == ex_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// IF/ID register, EX load tracker and stall/flush control for a 5-stage pipe.
// Ports: fetch (if_*), branch resolve from EX in; IF/ID contents, PC control,
// ID/EX bubble and stall out. Control outputs are combinational on state.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [5:0] LW_OP  = 6'h23,
  parameter logic [5:0] J_OP   = 6'h02,
  parameter logic [5:0] JAL_OP = 6'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc4,
  input  logic        ex_branch_taken,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic [31:0] jump_target,
  output logic        idex_bubble,
  output logic        stall
);

  ctrl_state_t state;
  logic        ex_load;
  logic [4:0]  ex_rt;
  logic        raw_hazard;
  logic        is_jump;
  logic        flush;

  hazard_detect #(
    .J_OP   (J_OP),
    .JAL_OP (JAL_OP)
  ) u_hazard (
    .id_valid (id_valid),
    .id_hi    (id_instr[31:16]),
    .ex_load  (ex_load),
    .ex_rt    (ex_rt),
    .hazard   (raw_hazard),
    .is_jump  (is_jump)
  );

  assign jump_target = {id_pc4[31:28], id_instr[25:0], 2'b00};

  // Priority: reset > taken branch > load-use stall > jump > sequential.
  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = PC_SEL_SEQ;
    idex_bubble = !id_valid;
    stall       = 1'b0;
    flush       = 1'b0;
    if (reset) begin
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      pc_sel      = PC_SEL_BRANCH;
      idex_bubble = 1'b1;
      flush       = 1'b1;
    end else if (raw_hazard && (state != ST_FLUSH)) begin
      stall       = 1'b1;
      pc_write    = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_valid && is_jump) begin
      // The jump itself still moves into ID/EX so JAL can write its link.
      pc_sel = PC_SEL_JUMP;
      flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc4   <= '0;
      ex_load  <= 1'b0;
      ex_rt    <= '0;
      state    <= ST_RUN;
    end else begin
      // IF/ID: flush kills the fetched slot, stall holds the current one.
      if (flush) begin
        id_valid <= 1'b0;
      end else if (!stall) begin
        id_valid <= if_valid;
        id_instr <= if_instr;
        id_pc4   <= if_pc4;
      end

      // The bubble clears ex_load, so a given hazard stalls exactly once.
      if (idex_bubble) begin
        ex_load <= 1'b0;
        ex_rt   <= '0;
      end else begin
        ex_load <= (id_instr[31:26] == LW_OP);
        ex_rt   <= id_instr[20:16];
      end

      if (flush)      state <= ST_FLUSH;
      else if (stall) state <= ST_STALL;
      else            state <= ST_RUN;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter LW_OP, default 6'h23, load-word opcode.
REQ-002 Parameter J_OP, default 6'h02, jump opcode.
REQ-003 Parameter JAL_OP, default 6'h03, jump-and-link opcode.
REQ-004 Single clock; reset synchronous, active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 if_valid  in  1  fetch presents a valid instruction.
REQ-008 if_instr  in  32  fetched instruction word.
REQ-009 if_pc4  in  32  PC+4 of fetched instruction.
REQ-010 ex_branch_taken  in  1  EX stage resolved a taken branch this cycle.
REQ-011 id_valid  out  1  IF/ID register holds a live instruction.
REQ-012 id_instr  out  32  IF/ID instruction.
REQ-013 id_pc4  out  32  IF/ID PC+4.
REQ-014 pc_write  out  1  PC may advance.
REQ-015 pc_sel  out  2  0 sequential, 1 jump, 2 branch.
REQ-016 jump_target  out  32  {id_pc4[31:28], id_instr[25:0], 2'b00}.
REQ-017 idex_bubble  out  1  ID/EX loads a NOP this cycle.
REQ-018 stall  out  1  load-use stall active.

Function
REQ-019 IF/ID register loads if_instr/if_pc4, id_valid<=if_valid, on every edge where neither stall nor flush is active.
REQ-020 Internal EX tracker: ex_load, ex_rt[4:0] register the ID instruction's "is LW_OP" and rt when ID/EX advances; cleared (ex_load=0) when idex_bubble=1.
REQ-021 ID source use: rs used for all opcodes except J/JAL; rt used when opcode=0 (R-type), 6'h2B (sw) or 6'h04/6'h05 (beq/bne).
REQ-022 Load-use hazard (combinational): id_valid & ex_load & ex_rt!=0 & ex_rt matches a used source -> stall=1.
REQ-023 On stall: pc_write=0, IF/ID holds, idex_bubble=1; exactly one stall cycle per hazard, since the bubble clears ex_load.
REQ-024 Jump: id_valid & opcode in {J_OP, JAL_OP} & !stall -> pc_sel=1, next-edge IF/ID id_valid<=0 (one flush bubble); ID/EX still takes the jump (JAL link).
REQ-025 Branch: ex_branch_taken -> pc_sel=2, pc_write=1, next-edge id_valid<=0, idex_bubble=1; overrides stall and jump in the same cycle.
REQ-026 Priority: reset > ex_branch_taken > stall > jump > sequential.
REQ-027 State machine RUN/STALL/FLUSH: RUN default; STALL for the cycle a load-use hazard holds; FLUSH for the cycle after a jump or taken branch (id_valid=0, no hazard evaluated); FLUSH->RUN, STALL->RUN unconditionally.
REQ-028 Default outputs: pc_write=1, pc_sel=0, idex_bubble=!id_valid.
REQ-029 rt=0 or rs=0 never triggers a stall (register $zero).
REQ-030 if_valid=0 with no stall: IF/ID loads id_valid=0; no spurious hazard.

Reset
REQ-031 Reset cycle: id_valid=0, id_instr=0, id_pc4=0, ex_load=0, ex_rt=0, state=RUN.
REQ-032 During reset: pc_write=1, pc_sel=0, stall=0, idex_bubble=1.
REQ-033 Reset asserted mid-stall or mid-flush discards the pending action; first post-reset cycle is RUN.

Structure
REQ-034 Shared package holds opcode constants (LW, SW, BEQ, BNE, J, JAL), pc_sel encodings, state encodings.
REQ-035 One sub-module hazard_detect: combinational source-use decode and load-use compare; all registers stay in pipeline_ctrl.

Verification
REQ-036 lw $5,0($1) then add $6,$5,$2 -> one cycle stall=1, pc_write=0, idex_bubble=1; add re-issues next cycle.
REQ-037 lw $0,0($1) then add $6,$0,$2 -> stall stays 0.
REQ-038 j 0x0000040 at id_pc4=0x10000004 -> pc_sel=1, jump_target=0x10000100, id_valid=0 next cycle.
REQ-039 Stall condition and ex_branch_taken=1 same cycle -> pc_sel=2, pc_write=1, stall=0, id_valid=0 next cycle.
REQ-040 reset=1 during STALL -> next cycle all REQ-031 values, no residual stall after reset release.
REQ-041 lw $5 then sw $5,4($3) -> stall one cycle (rt used by store).
